ipsl_pcie_dma_ram_wr_arb: RTL and testbench
===========================================

# ipsl_pcie_dma_ram_wr_arb

Two-requester write arbiter for the DMA BAR RAM write port. It merges the RAM write streams from the MWr write controller and the CplD write controller onto one RAM write port. Neither source accepts back-pressure, so each has its own small FIFO; a round-robin scheduler drains the FIFOs at one beat per cycle. The block sits between the rx write controllers and the BAR RAM.

## Interface
- ADDR_WIDTH, 9, RAM word address width
- FIFO_AW, 3, per-requester FIFO address width (depth 2^FIFO_AW = 8)
- CPLD_BAR, 2'd1, bar_hit value driven for CplD-sourced writes

Ports:
- clk  in  1  single clock domain; everything is clocked on its rising edge
- rst  in  1  synchronous, active-high reset
- i_mwr_wr_en  in  1  MWr beat valid
- i_mwr_wr_addr  in  ADDR_WIDTH  MWr RAM address
- i_mwr_wr_data  in  128  MWr data
- i_mwr_wr_be  in  16  MWr byte enables
- i_mwr_wr_bar_hit  in  2  MWr target BAR
- i_cpld_wr_en  in  1  CplD beat valid
- i_cpld_wr_addr  in  ADDR_WIDTH  CplD RAM address
- i_cpld_wr_data  in  128  CplD data
- i_cpld_wr_be  in  16  CplD byte enables
- i_ovf_clr  in  1  clears both overflow flags
- o_ram_wr_en  out  1  RAM write strobe (registered)
- o_ram_wr_addr  out  ADDR_WIDTH  RAM address
- o_ram_wr_data  out  128  RAM data
- o_ram_wr_be  out  16  RAM byte enables
- o_ram_wr_bar_hit  out  2  BAR of the current write
- o_mwr_ovf  out  1  sticky: an MWr beat was dropped
- o_cpld_ovf  out  1  sticky: a CplD beat was dropped
- o_idle  out  1  both FIFOs are empty and o_ram_wr_en=0

## Operation
- Each requester has a FIFO of depth 2^FIFO_AW.
  - MWr entry width: ADDR_WIDTH+128+16+2 (addr, data, be, bar_hit).
  - CplD entry: addr, data and be; bar_hit is taken as CPLD_BAR at the output.
- Push: on wr_en=1 with the FIFO not full.
  - Full is evaluated from the pre-edge count, so a pop in the same cycle does not make room.
  - A beat arriving while full is dropped and sets its ovf flag.
- Occupancy counters are FIFO_AW+1 bits; read/write pointers wrap modulo the depth.
- Scheduler runs every cycle:
  - Both FIFOs non-empty: grant the requester not granted last.
  - One FIFO non-empty: grant that one.
  - Both empty: no grant.
  - The granted FIFO pops in that cycle.
- last_gnt register: 0=MWr, 1=CplD.
  - Updated only on a grant.
  - Resets to 1 (CplD), so MWr wins the first tie.
- Output register loads the popped entry. o_ram_wr_en=1 exactly in the cycle after a grant, otherwise 0.
  - addr/data/be/bar_hit hold their last values when en=0.
- Ordering is preserved within each requester. No ordering is guaranteed across requesters.
- ovf flags: set has priority over i_ovf_clr in the same cycle. They are cleared only by i_ovf_clr or rst.
- Reset (including mid-burst):
  - FIFOs flush (pointers/counts = 0); last_gnt = 1.
  - All outputs = 0; o_idle = 1.
  - Input beats in the reset cycle are discarded.

## Timing
- Uncontended latency: beat on input at cycle N → written to FIFO at edge N → granted at N+1 → o_ram_wr_en=1 at N+2.
- Aggregate throughput: 1 RAM write per cycle. Under continuous contention each requester gets 1/2.
- A single requester streaming alone never overflows: push and pop are 1/cycle and occupancy stays at 1.
- o_idle is combinational from the counts and o_ram_wr_en. It goes to 1 in the cycle after the last output beat.

## Test plan
- **Single beat:** one MWr beat at cycle 0 (addr=0x12, data=0xA5.., be=0xFFFF, bar=0) → o_ram_wr_en=1 only at cycle 2 with the same fields; o_idle=0 during cycles 1-2 and 1 at cycle 3.
- **First tie:** MWr and CplD each push 1 beat at cycle 0 → MWr written at cycle 2, CplD at cycle 3 with bar_hit=CPLD_BAR.
- **Contention overflow:** both push 20 consecutive beats, cycles 0-19, with data = beat index.
  - MWr beats 15, 17, 19 and CplD beats 14, 16, 18 are dropped.
  - Both ovf flags = 1.
  - 34 writes occur, alternating MWr/CplD starting with MWr; each stream's surviving beats stay in order.
- **Clear vs set:** assert i_ovf_clr in a cycle where an MWr drop occurs → o_mwr_ovf stays 1 and o_cpld_ovf goes to 0 (if no CplD drop that cycle). A later i_ovf_clr with no drop clears both.
- **Reset mid-operation:** fill both FIFOs with 6 beats each, then pulse rst for 1 cycle.
  - Outputs = 0 and o_idle=1 the next cycle; no stale writes ever appear.
  - A fresh MWr beat then follows the 2-cycle latency.
- **Pointer wrap:** MWr alone streams 40 beats with incrementing addr → 40 in-order writes, each 2 cycles after its input, no ovf.

Source files
------------

// File: rtl/ipsl_pcie_dma_ram_wr_arb.sv
// Two-requester round-robin write arbiter for the DMA BAR RAM write port.
// MWr and CplD streams each land in a small FIFO; one beat per cycle is
// drained onto a registered RAM write port.
module ipsl_pcie_dma_ram_wr_arb #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned FIFO_AW    = 3,
   parameter logic [1:0]  CPLD_BAR   = 2'd1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_mwr_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_mwr_wr_addr,
   input  logic [127:0]          i_mwr_wr_data,
   input  logic [15:0]           i_mwr_wr_be,
   input  logic [1:0]            i_mwr_wr_bar_hit,
   input  logic                  i_cpld_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_cpld_wr_addr,
   input  logic [127:0]          i_cpld_wr_data,
   input  logic [15:0]           i_cpld_wr_be,
   input  logic                  i_ovf_clr,
   output logic                  o_ram_wr_en,
   output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
   output logic [127:0]          o_ram_wr_data,
   output logic [15:0]           o_ram_wr_be,
   output logic [1:0]            o_ram_wr_bar_hit,
   output logic                  o_mwr_ovf,
   output logic                  o_cpld_ovf,
   output logic                  o_idle
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [127:0]          data;
      logic [15:0]           be;
      logic [1:0]            bar_hit;
   } ram_wr_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [127:0]          data;
      logic [15:0]           be;
   } cpld_ent_t;

   ram_wr_t            mwr_mem  [DEPTH];
   cpld_ent_t          cpld_mem [DEPTH];

   logic [FIFO_AW-1:0] mwr_wp, mwr_rp, cpld_wp, cpld_rp;
   logic [FIFO_AW-1:0] mwr_wp_nxt, mwr_rp_nxt, cpld_wp_nxt, cpld_rp_nxt;
   logic [CW-1:0]      mwr_cnt, cpld_cnt, mwr_cnt_nxt, cpld_cnt_nxt;
   logic               last_gnt, last_gnt_nxt;
   logic               ram_en_q, ram_en_nxt;
   ram_wr_t            ram_q, ram_nxt;
   logic               mwr_ovf_q, mwr_ovf_nxt, cpld_ovf_q, cpld_ovf_nxt;

   logic               mwr_full, mwr_empty, mwr_push, mwr_drop;
   logic               cpld_full, cpld_empty, cpld_push, cpld_drop;
   logic               gnt_mwr, gnt_cpld;
   ram_wr_t            mwr_in, mwr_head;
   cpld_ent_t          cpld_in, cpld_head;

   assign mwr_head  = mwr_mem[mwr_rp];
   assign cpld_head = cpld_mem[cpld_rp];

   // Push/drop decisions, round-robin grant and next-state for all registers
   always_comb begin
      mwr_in       = '{addr: i_mwr_wr_addr, data: i_mwr_wr_data,
                       be: i_mwr_wr_be, bar_hit: i_mwr_wr_bar_hit};
      cpld_in      = '{addr: i_cpld_wr_addr, data: i_cpld_wr_data,
                       be: i_cpld_wr_be};
      mwr_full     = (mwr_cnt == CW'(DEPTH));
      cpld_full    = (cpld_cnt == CW'(DEPTH));
      mwr_empty    = (mwr_cnt == '0);
      cpld_empty   = (cpld_cnt == '0);
      mwr_push     = i_mwr_wr_en & ~mwr_full;
      cpld_push    = i_cpld_wr_en & ~cpld_full;
      mwr_drop     = i_mwr_wr_en & mwr_full;
      cpld_drop    = i_cpld_wr_en & cpld_full;

      // on a tie the requester not granted last wins
      gnt_mwr      = ~mwr_empty & (cpld_empty | last_gnt);
      gnt_cpld     = ~cpld_empty & ~gnt_mwr;

      mwr_cnt_nxt  = mwr_cnt + CW'(mwr_push) - CW'(gnt_mwr);
      cpld_cnt_nxt = cpld_cnt + CW'(cpld_push) - CW'(gnt_cpld);
      mwr_wp_nxt   = mwr_push  ? mwr_wp + FIFO_AW'(1)  : mwr_wp;
      cpld_wp_nxt  = cpld_push ? cpld_wp + FIFO_AW'(1) : cpld_wp;
      mwr_rp_nxt   = gnt_mwr   ? mwr_rp + FIFO_AW'(1)  : mwr_rp;
      cpld_rp_nxt  = gnt_cpld  ? cpld_rp + FIFO_AW'(1) : cpld_rp;

      last_gnt_nxt = last_gnt;
      ram_en_nxt   = gnt_mwr | gnt_cpld;
      ram_nxt      = ram_q;
      if (gnt_mwr) begin
         last_gnt_nxt = 1'b0;
         ram_nxt      = mwr_head;
      end else if (gnt_cpld) begin
         last_gnt_nxt = 1'b1;
         ram_nxt      = '{addr: cpld_head.addr, data: cpld_head.data,
                          be: cpld_head.be, bar_hit: CPLD_BAR};
      end

      // a drop in the same cycle beats the clear
      mwr_ovf_nxt  = mwr_drop  | (mwr_ovf_q  & ~i_ovf_clr);
      cpld_ovf_nxt = cpld_drop | (cpld_ovf_q & ~i_ovf_clr);
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         mwr_wp     <= '0;
         mwr_rp     <= '0;
         cpld_wp    <= '0;
         cpld_rp    <= '0;
         mwr_cnt    <= '0;
         cpld_cnt   <= '0;
         last_gnt   <= 1'b1;
         ram_en_q   <= 1'b0;
         ram_q      <= '0;
         mwr_ovf_q  <= 1'b0;
         cpld_ovf_q <= 1'b0;
      end else begin
         mwr_wp     <= mwr_wp_nxt;
         mwr_rp     <= mwr_rp_nxt;
         cpld_wp    <= cpld_wp_nxt;
         cpld_rp    <= cpld_rp_nxt;
         mwr_cnt    <= mwr_cnt_nxt;
         cpld_cnt   <= cpld_cnt_nxt;
         last_gnt   <= last_gnt_nxt;
         ram_en_q   <= ram_en_nxt;
         ram_q      <= ram_nxt;
         mwr_ovf_q  <= mwr_ovf_nxt;
         cpld_ovf_q <= cpld_ovf_nxt;
      end
   end

   // FIFO storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (!rst && mwr_push) begin
         mwr_mem[mwr_wp] <= mwr_in;
      end
      if (!rst && cpld_push) begin
         cpld_mem[cpld_wp] <= cpld_in;
      end
   end

   assign o_ram_wr_en      = ram_en_q;
   assign o_ram_wr_addr    = ram_q.addr;
   assign o_ram_wr_data    = ram_q.data;
   assign o_ram_wr_be      = ram_q.be;
   assign o_ram_wr_bar_hit = ram_q.bar_hit;
   assign o_mwr_ovf        = mwr_ovf_q;
   assign o_cpld_ovf       = cpld_ovf_q;
   assign o_idle           = mwr_empty & cpld_empty & ~ram_en_q;

endmodule

// File: tb/tb_ipsl_pcie_dma_ram_wr_arb.sv
// Scoreboard bench for ipsl_pcie_dma_ram_wr_arb: directed stimulus pushes
// expected RAM writes (with expected cycle); a forked monitor checks them.
module tb_ipsl_pcie_dma_ram_wr_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_mwr_wr_en;
   logic [8:0]   i_mwr_wr_addr;
   logic [127:0] i_mwr_wr_data;
   logic [15:0]  i_mwr_wr_be;
   logic [1:0]   i_mwr_wr_bar_hit;
   logic         i_cpld_wr_en;
   logic [8:0]   i_cpld_wr_addr;
   logic [127:0] i_cpld_wr_data;
   logic [15:0]  i_cpld_wr_be;
   logic         i_ovf_clr;
   logic         o_ram_wr_en;
   logic [8:0]   o_ram_wr_addr;
   logic [127:0] o_ram_wr_data;
   logic [15:0]  o_ram_wr_be;
   logic [1:0]   o_ram_wr_bar_hit;
   logic         o_mwr_ovf;
   logic         o_cpld_ovf;
   logic         o_idle;

   ipsl_pcie_dma_ram_wr_arb #(.ADDR_WIDTH(9), .FIFO_AW(3), .CPLD_BAR(2'd1)) dut (
      .clk(clk), .rst(rst),
      .i_mwr_wr_en(i_mwr_wr_en), .i_mwr_wr_addr(i_mwr_wr_addr),
      .i_mwr_wr_data(i_mwr_wr_data), .i_mwr_wr_be(i_mwr_wr_be),
      .i_mwr_wr_bar_hit(i_mwr_wr_bar_hit),
      .i_cpld_wr_en(i_cpld_wr_en), .i_cpld_wr_addr(i_cpld_wr_addr),
      .i_cpld_wr_data(i_cpld_wr_data), .i_cpld_wr_be(i_cpld_wr_be),
      .i_ovf_clr(i_ovf_clr),
      .o_ram_wr_en(o_ram_wr_en), .o_ram_wr_addr(o_ram_wr_addr),
      .o_ram_wr_data(o_ram_wr_data), .o_ram_wr_be(o_ram_wr_be),
      .o_ram_wr_bar_hit(o_ram_wr_bar_hit),
      .o_mwr_ovf(o_mwr_ovf), .o_cpld_ovf(o_cpld_ovf), .o_idle(o_idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [8:0]   addr;
      logic [127:0] data;
      logic [15:0]  be;
      logic [1:0]   bar;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   // surviving beat indices under 20-beat contention
   int m_surv [17] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,16,18};
   int c_surv [17] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,15,17,19};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic exp_push(input logic [8:0] a, input logic [127:0] d,
                           input logic [15:0] b, input logic [1:0] h, input int c);
      exp_t x;
      x.addr = a; x.data = d; x.be = b; x.bar = h; x.cyc = c;
      exp_q.push_back(x);
   endtask

   task automatic quiet_inputs();
      i_mwr_wr_en      = 1'b0;
      i_mwr_wr_addr    = '0;
      i_mwr_wr_data    = '0;
      i_mwr_wr_be      = '0;
      i_mwr_wr_bar_hit = '0;
      i_cpld_wr_en     = 1'b0;
      i_cpld_wr_addr   = '0;
      i_cpld_wr_data   = '0;
      i_cpld_wr_be     = '0;
      i_ovf_clr        = 1'b0;
   endtask

   task automatic drive_mwr(input logic [8:0] a, input logic [127:0] d,
                            input logic [15:0] b, input logic [1:0] h);
      i_mwr_wr_en = 1'b1; i_mwr_wr_addr = a; i_mwr_wr_data = d;
      i_mwr_wr_be = b; i_mwr_wr_bar_hit = h;
   endtask

   task automatic drive_cpld(input logic [8:0] a, input logic [127:0] d, input logic [15:0] b);
      i_cpld_wr_en = 1'b1; i_cpld_wr_addr = a; i_cpld_wr_data = d; i_cpld_wr_be = b;
   endtask

   task automatic check_reset_state(input string name);
      chk(name, 32'({o_ram_wr_en, |o_ram_wr_addr, |o_ram_wr_data, |o_ram_wr_be,
                     |o_ram_wr_bar_hit, o_mwr_ovf, o_cpld_ovf, o_idle}), 32'h01);
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 200; k++) begin
         tick();
         if (o_idle && exp_q.size() == 0) break;
      end
      chk(name, 32'({o_idle, exp_q.size() == 0}), 32'h3);
   endtask

   initial begin
      logic [127:0] a5;
      int n;
      a5 = {16{8'hA5}};
      rst = 1'b1;
      quiet_inputs();

      // monitor: every RAM write must match the head of the scoreboard
      fork
         forever begin
            @(negedge clk);
            if (o_ram_wr_en) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_write: got addr=%h data=%h at cycle %0d, expected no write",
                           o_ram_wr_addr, o_ram_wr_data, cyc);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (o_ram_wr_addr !== mon_e.addr || o_ram_wr_data !== mon_e.data ||
                      o_ram_wr_be !== mon_e.be || o_ram_wr_bar_hit !== mon_e.bar ||
                      cyc != mon_e.cyc) begin
                     fails++;
                     $display("FAIL ram_write: got cyc=%0d addr=%h data=%h be=%h bar=%0d, expected cyc=%0d addr=%h data=%h be=%h bar=%0d",
                              cyc, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_be, o_ram_wr_bar_hit,
                              mon_e.cyc, mon_e.addr, mon_e.data, mon_e.be, mon_e.bar);
                  end
               end
            end
         end
      join_none

      do_reset();
      check_reset_state("reset_state");

      // first tie after reset goes to MWr
      n = cyc;
      exp_push(9'h020, 128'h1111, 16'hFFFF, 2'd0, n + 2);
      exp_push(9'h030, 128'h2222, 16'h00FF, 2'd1, n + 3);
      drive_mwr(9'h020, 128'h1111, 16'hFFFF, 2'd0);
      drive_cpld(9'h030, 128'h2222, 16'h00FF);
      tick();
      quiet_inputs();
      wait_drain("tie_drain");

      // single beat latency and idle timing
      n = cyc;
      exp_push(9'h012, a5, 16'hFFFF, 2'd0, n + 2);
      chk("idle_before", 32'(o_idle), 32'd1);
      drive_mwr(9'h012, a5, 16'hFFFF, 2'd0);
      tick();
      quiet_inputs();
      chk("idle_c1", 32'(o_idle), 32'd0);
      tick();
      chk("idle_c2", 32'(o_idle), 32'd0);
      tick();
      chk("idle_c3", 32'(o_idle), 32'd1);

      // contention overflow with clear-vs-set at beat 15
      do_reset();
      n = cyc;
      for (int k = 0; k < 17; k++) begin
         exp_push(9'(9'h100 + m_surv[k]), 128'(m_surv[k]), 16'hFFFF, 2'd2, n + 2 + 2*k);
         exp_push(9'(9'h080 + c_surv[k]), 128'(c_surv[k]), 16'h0F0F, 2'd1, n + 3 + 2*k);
      end
      for (int i = 0; i < 20; i++) begin
         drive_mwr(9'(9'h100 + i), 128'(i), 16'hFFFF, 2'd2);
         drive_cpld(9'(9'h080 + i), 128'(i), 16'h0F0F);
         i_ovf_clr = (i == 15);
         if (i == 15) chk("ovf_before_clr", 32'({o_mwr_ovf, o_cpld_ovf}), 32'h1);
         tick();
         if (i == 15) chk("ovf_clr_vs_set", 32'({o_mwr_ovf, o_cpld_ovf}), 32'h2);
      end
      quiet_inputs();
      wait_drain("contention_drain");
      chk("ovf_after_contention", 32'({o_mwr_ovf, o_cpld_ovf}), 32'h3);
      i_ovf_clr = 1'b1;
      tick();
      i_ovf_clr = 1'b0;
      chk("ovf_clear_both", 32'({o_mwr_ovf, o_cpld_ovf}), 32'h0);

      // reset while both FIFOs hold data
      do_reset();
      n = cyc;
      exp_push(9'h040, 128'h40, 16'hFFFF, 2'd0, n + 2);
      exp_push(9'h050, 128'h50, 16'h00FF, 2'd1, n + 3);
      exp_push(9'h041, 128'h41, 16'hFFFF, 2'd0, n + 4);
      exp_push(9'h051, 128'h51, 16'h00FF, 2'd1, n + 5);
      exp_push(9'h042, 128'h42, 16'hFFFF, 2'd0, n + 6);
      for (int i = 0; i < 6; i++) begin
         drive_mwr(9'(9'h040 + i), 128'(9'h040 + i), 16'hFFFF, 2'd0);
         drive_cpld(9'(9'h050 + i), 128'(9'h050 + i), 16'h00FF);
         tick();
      end
      i_cpld_wr_en = 1'b0;
      drive_mwr(9'h1FF, 128'hDEAD, 16'hFFFF, 2'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      quiet_inputs();
      check_reset_state("mid_reset_state");
      chk("mid_reset_queue_empty", 32'(exp_q.size()), 32'd0);
      repeat (6) tick();
      n = cyc;
      exp_push(9'h0AB, 128'hBEEF, 16'h1234, 2'd3, n + 2);
      drive_mwr(9'h0AB, 128'hBEEF, 16'h1234, 2'd3);
      tick();
      quiet_inputs();
      wait_drain("post_reset_drain");

      // MWr alone across several pointer wraps
      n = cyc;
      for (int i = 0; i < 40; i++) begin
         exp_push(9'(i), 128'(1000 + i), 16'hFFFF, 2'd1, n + 2 + i);
      end
      for (int i = 0; i < 40; i++) begin
         drive_mwr(9'(i), 128'(1000 + i), 16'hFFFF, 2'd1);
         tick();
      end
      quiet_inputs();
      wait_drain("wrap_drain");
      chk("wrap_no_ovf", 32'({o_mwr_ovf, o_cpld_ovf}), 32'h0);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // hard stop if the run ever hangs
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
